// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - op_e    : 3-bit memory operation encoding as presented on the request port
//   - state_e : control FSM states
//   - lane widths used by the byte/halfword select and merge logic
//   - helpers : alignment check and load/store classification
package lsu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_READ,
        ST_RMW_WRITE,
        ST_RESP
    } state_e;

    // Halfword ops need an even address, word ops a word-aligned one.
    function automatic logic is_misaligned(input op_e op, input logic [1:0] offset);
        logic bad;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = offset[0];
            OP_LW, OP_SW:         bad = |offset;
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic is_load(input op_e op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic shared by the load and read-modify-write paths.
// Ports:
//   op_i         operation being executed
//   offset_i     byte offset within the word (addr[1:0])
//   src_word_i   word read from RAM (loads) or captured word (sub-word stores)
//   wdata_i      right-aligned store data
//   load_data_o  selected byte/half/word, sign- or zero-extended to 32 bits
//   merge_data_o src_word_i with the addressed byte/half replaced (SW: wdata_i)
module lsu_align
    import lsu_pkg::*;
(
    input  op_e               op_i,
    input  logic [1:0]        offset_i,
    input  logic [WORD_W-1:0] src_word_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] load_data_o,
    output logic [WORD_W-1:0] merge_data_o
);

    logic [4:0]        byte_shift;
    logic [4:0]        half_shift;
    logic [BYTE_W-1:0] byte_val;
    logic [HALF_W-1:0] half_val;

    // Little-endian lanes: offset 0 is bits 7:0, halfword offset[1]=0 is bits 15:0.
    assign byte_shift = {offset_i, 3'b000};
    assign half_shift = {offset_i[1], 4'b0000};
    assign byte_val   = src_word_i[byte_shift +: BYTE_W];
    assign half_val   = src_word_i[half_shift +: HALF_W];

    always_comb begin
        load_data_o = '0;
        case (op_i)
            OP_LB:   load_data_o = {{(WORD_W-BYTE_W){byte_val[BYTE_W-1]}}, byte_val};
            OP_LH:   load_data_o = {{(WORD_W-HALF_W){half_val[HALF_W-1]}}, half_val};
            OP_LW:   load_data_o = src_word_i;
            OP_LBU:  load_data_o = {{(WORD_W-BYTE_W){1'b0}}, byte_val};
            OP_LHU:  load_data_o = {{(WORD_W-HALF_W){1'b0}}, half_val};
            default: load_data_o = '0;
        endcase
    end

    always_comb begin
        merge_data_o = wdata_i;
        case (op_i)
            OP_SB: begin
                merge_data_o = src_word_i;
                merge_data_o[byte_shift +: BYTE_W] = wdata_i[BYTE_W-1:0];
            end
            OP_SH: begin
                merge_data_o = src_word_i;
                merge_data_o[half_shift +: HALF_W] = wdata_i[HALF_W-1:0];
            end
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the EX/MEM pipeline register and a data RAM with
// combinational read data. One request in flight at a time.
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   req_valid / req_ready  request handshake (ready only in IDLE)
//   op, addr, wdata        operation, byte address, right-aligned store data
//   resp_valid             one-cycle completion pulse
//   rdata, misalign_err    load result / misalignment flag, held until next response
//   mem_addr, mem_wdata    word-aligned RAM address and full write word
//   mem_write_en           RAM write strobe, mem_read_en RAM read enable
//   mem_rdata              RAM combinational read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              misalign_q, misalign_d;

    op_e               op_in;
    logic [DATA_W-1:0] align_src;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    assign op_in = op_e'(op);

    // The RMW write uses the word captured in RMW_READ; loads use live RAM data.
    assign align_src = (state_q == ST_RMW_WRITE) ? word_q : mem_rdata;

    lsu_align u_align (
        .op_i         (op_q),
        .offset_i     (addr_q[1:0]),
        .src_word_i   (align_src),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_LB;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    // Result registers are only rewritten on entry to RESP, so they hold
    // between responses.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = op_in;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (is_misaligned(op_in, addr[1:0])) begin
                        state_d    = ST_RESP;
                        rdata_d    = '0;
                        misalign_d = 1'b1;
                    end else if (is_load(op_in)) begin
                        state_d = ST_LOAD;
                    end else if (op_in == OP_SW) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_RMW_READ;
                    end
                end
            end
            ST_LOAD: begin
                state_d    = ST_RESP;
                rdata_d    = load_data;
                misalign_d = 1'b0;
            end
            ST_STORE: begin
                state_d    = ST_RESP;
                rdata_d    = '0;
                misalign_d = 1'b0;
            end
            ST_RMW_READ: begin
                state_d = ST_RMW_WRITE;
                word_d  = mem_rdata;
            end
            ST_RMW_WRITE: begin
                state_d    = ST_RESP;
                rdata_d    = '0;
                misalign_d = 1'b0;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are gated by reset so an in-flight write is dropped, not committed.
    always_comb begin
        req_ready    = (state_q == ST_IDLE) && !reset;
        mem_read_en  = ((state_q == ST_LOAD) || (state_q == ST_RMW_READ)) && !reset;
        mem_write_en = ((state_q == ST_STORE) || (state_q == ST_RMW_WRITE)) && !reset;
        resp_valid   = (state_q == ST_RESP) && !reset;
        mem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata    = (state_q == ST_STORE) ? wdata_q : merge_data;
        rdata        = rdata_q;
        misalign_err = misalign_q;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width.
REQ-002 Parameter: DATA_W, default 32, word width; only 32 is supported.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req_valid  in  1  memory op request from EX/MEM pipeline register.
REQ-006 req_ready  out  1  unit can accept a request; 1 only in IDLE.
REQ-007 op  in  3  0=LB, 1=LH, 2=LW, 3=LBU, 4=LHU, 5=SB, 6=SH, 7=SW.
REQ-008 addr  in  ADDR_W  byte address.
REQ-009 wdata  in  DATA_W  store data, right-aligned.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 rdata  out  DATA_W  extended load result; valid with resp_valid.
REQ-012 misalign_err  out  1  qualifies resp_valid; access was misaligned.
REQ-013 mem_addr  out  ADDR_W  to data RAM; always word-aligned (addr[1:0]=0).
REQ-014 mem_wdata  out  DATA_W  full word to RAM.
REQ-015 mem_write_en  out  1  RAM write strobe; word committed at rising edge.
REQ-016 mem_read_en  out  1  RAM read enable.
REQ-017 mem_rdata  in  DATA_W  RAM combinational read data.

Function
REQ-018 FSM states: IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP.
REQ-019 A request is accepted when req_valid=1 and req_ready=1 (IDLE); op, addr and wdata are latched on that edge.
REQ-020 Alignment rule: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0; a violation goes IDLE->RESP with misalign_err=1 and no RAM access.
REQ-021 Loads: IDLE->LOAD->RESP; LOAD drives mem_read_en=1 and mem_addr={addr[31:2],2'b00}, and the extracted result is captured on exit.
REQ-022 Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0; halfword addr[1]=0 selects bits 15:0.
REQ-023 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-024 SW: IDLE->STORE->RESP; STORE drives mem_write_en=1 for exactly one cycle with mem_wdata=wdata.
REQ-025 SB/SH: IDLE->RMW_READ->RMW_WRITE->RESP.
REQ-026 RMW_READ captures mem_rdata.
REQ-027 RMW_WRITE writes the captured word with only the addressed byte/half replaced by wdata[7:0]/wdata[15:0].
REQ-028 RESP asserts resp_valid=1 for one cycle and then returns to IDLE; a new request is not accepted in RESP.
REQ-029 Latency from acceptance edge to resp_valid: LW/LB/LH/LBU/LHU/SW 2 cycles, SB/SH 3 cycles, misaligned 1 cycle.
REQ-030 mem_read_en=1 only in LOAD and RMW_READ; mem_write_en=1 only in STORE and RMW_WRITE; both are 0 elsewhere.
REQ-031 rdata and misalign_err hold their value until the next RESP; rdata is 0 for stores and misaligned ops.
REQ-032 Address wrap: no special case; mem_addr is the truncated word address.

Reset
REQ-033 On a clock edge with reset=1, the FSM goes to IDLE and the latched op, addr, wdata and captured word clear to 0.
REQ-034 After that reset edge, rdata=0, misalign_err=0 and resp_valid=0.
REQ-035 While reset=1, mem_write_en, mem_read_en and resp_valid are forced to 0 combinationally, so a reset mid-STORE or mid-RMW_WRITE commits nothing.
REQ-036 While reset=1, req_ready=0.
REQ-037 req_ready=1 in the first cycle after reset deasserts.

Structure
REQ-038 A shared package lsu_pkg holds the op encodings, the FSM state enum and the byte/half lane-select constants.
REQ-039 One sub-module, lsu_align, is combinational and implements extraction/extension for loads and merge for sub-word stores; it is reused by the load and RMW paths.

Verification
REQ-040 RAM word 0x44=0x00000068: LW addr 0x44 -> resp_valid 2 cycles after accept, rdata=0x00000068, misalign_err=0.
REQ-041 SB wdata=0x000000FF at addr 0x45 on word 0x00000068 -> exactly one mem_write_en pulse with mem_wdata=0x0000FF68, resp_valid after 3 cycles.
REQ-042 Follow-up to REQ-041: LB 0x45 -> rdata 0xFFFFFFFF; LBU 0x45 -> 0x000000FF; LHU 0x44 -> 0x0000FF68.
REQ-043 LW addr 0x02 and SH addr 0x03 -> misalign_err=1 one cycle after accept, no mem_read_en or mem_write_en, rdata=0.
REQ-044 Assert reset during RMW_WRITE of SH 0xABCD at 0x00 on word 0x00000003 -> mem_write_en stays 0, word stays 0x00000003, req_ready=1 the cycle after reset falls.
REQ-045 Back-to-back requests with req_valid held high -> each accepted only in IDLE; req_ready=0 in all other states; no request lost or duplicated.
